// File: rtl/wb_dsp_equation_fetch.sv
// Fetches a 4-word DSP equation descriptor over a Wishbone classic read master and hands it
// to the engine. Optional ack watchdog is enabled by defining WB_DSP_FETCH_TIMEOUT_EN.
module wb_dsp_equation_fetch #(
  parameter int dw         = 32,
  parameter int aw         = 32,
  parameter int DESC_WORDS = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [dw-1:0] control_reg,
  input  logic [dw-1:0] equation0_address_reg,
  input  logic [dw-1:0] equation1_address_reg,
  input  logic [dw-1:0] equation2_address_reg,
  input  logic [dw-1:0] equation3_address_reg,
  output logic [dw-1:0] status_reg,
  output logic [aw-1:0] wb_adr_o,
  input  logic [dw-1:0] wb_dat_i,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  output logic [dw-1:0] desc_opcode,
  output logic [dw-1:0] desc_src,
  output logic [dw-1:0] desc_dst,
  output logic [dw-1:0] desc_count,
  output logic          desc_valid,
  input  logic          desc_ready,
  input  logic          engine_done
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] FETCH    = 3'd1;
  localparam logic [2:0] DISPATCH = 3'd2;
  localparam logic [2:0] EXECUTE  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;
  localparam logic [1:0] LAST_K   = 2'(DESC_WORDS - 1);

  logic [2:0]    state, nxt_state;
  logic [1:0]    k, nxt_k, sel, nxt_sel, nxt_code;
  logic [aw-1:0] base, nxt_base, nxt_adr;
  logic          start_d, start_edge, start_go, abort, timeout_hit;
  logic          done, err, timeout, nxt_done, nxt_err, nxt_timeout;
  logic          nxt_cyc, nxt_stb, nxt_valid, nxt_busy;
  logic [dw-1:0] nxt_opcode, nxt_src, nxt_dst, nxt_count, nxt_status, eq_raw;
  logic          unused_bits;

  assign wb_sel_o    = 4'hF;
  assign wb_we_o     = 1'b0;
  assign wb_cti_o    = 3'b000;
  assign wb_bte_o    = 2'b00;
  assign abort       = control_reg[31];
  assign start_edge  = control_reg[0] & ~start_d;
  assign unused_bits = ^{control_reg[30:3], eq_raw[1:0]};

  always_comb begin
    case (control_reg[2:1])
      2'd0:    eq_raw = equation0_address_reg;
      2'd1:    eq_raw = equation1_address_reg;
      2'd2:    eq_raw = equation2_address_reg;
      default: eq_raw = equation3_address_reg;
    endcase
  end

  // Every register, status included, is computed here so status_reg tracks state exactly.
  always_comb begin
    nxt_state   = state;
    nxt_k       = k;
    nxt_sel     = sel;
    nxt_base    = base;
    nxt_adr     = wb_adr_o;
    nxt_cyc     = wb_cyc_o;
    nxt_stb     = wb_stb_o;
    nxt_valid   = desc_valid;
    nxt_done    = done;
    nxt_err     = err;
    nxt_timeout = timeout;
    nxt_opcode  = desc_opcode;
    nxt_src     = desc_src;
    nxt_dst     = desc_dst;
    nxt_count   = desc_count;
    start_go    = 1'b0;
    if (abort) begin
      nxt_state = IDLE;
      nxt_cyc   = 1'b0;
      nxt_stb   = 1'b0;
      nxt_valid = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            start_go    = 1'b1;
            nxt_sel     = control_reg[2:1];
            nxt_base    = aw'({eq_raw[dw-1:2], 2'b00});
            nxt_adr     = aw'({eq_raw[dw-1:2], 2'b00});
            nxt_k       = 2'd0;
            nxt_done    = 1'b0;
            nxt_err     = 1'b0;
            nxt_timeout = 1'b0;
            nxt_cyc     = 1'b1;
            nxt_stb     = 1'b1;
            nxt_state   = FETCH;
          end
        end
        FETCH: begin
          if (!wb_stb_o) begin
            nxt_cyc = 1'b1;
            nxt_stb = 1'b1;
            nxt_adr = base + aw'({k, 2'b00});
          end else if (wb_err_i) begin
            nxt_cyc   = 1'b0;
            nxt_stb   = 1'b0;
            nxt_err   = 1'b1;
            nxt_state = DONE;
          end else if (wb_ack_i) begin
            nxt_cyc = 1'b0;
            nxt_stb = 1'b0;
            case (k)
              2'd0:    nxt_opcode = wb_dat_i;
              2'd1:    nxt_src    = wb_dat_i;
              2'd2:    nxt_dst    = wb_dat_i;
              default: nxt_count  = wb_dat_i;
            endcase
            if (k == LAST_K) begin
              nxt_valid = 1'b1;
              nxt_state = DISPATCH;
            end else begin
              nxt_k = k + 2'd1;
            end
          end else if (timeout_hit) begin
            nxt_cyc     = 1'b0;
            nxt_stb     = 1'b0;
            nxt_err     = 1'b1;
            nxt_timeout = 1'b1;
            nxt_state   = DONE;
          end
        end
        DISPATCH: begin
          if (desc_valid && desc_ready) begin
            nxt_valid = 1'b0;
            nxt_state = EXECUTE;
          end
        end
        EXECUTE: begin
          if (engine_done) begin
            nxt_done  = 1'b1;
            nxt_state = DONE;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_comb begin
    nxt_busy = (nxt_state == FETCH) || (nxt_state == DISPATCH) || (nxt_state == EXECUTE);
    case (nxt_state)
      FETCH:    nxt_code = 2'd1;
      DISPATCH: nxt_code = 2'd2;
      EXECUTE:  nxt_code = 2'd3;
      default:  nxt_code = 2'd0;
    endcase
    nxt_status        = '0;
    nxt_status[0]     = nxt_busy;
    nxt_status[1]     = nxt_done;
    nxt_status[2]     = nxt_err;
    nxt_status[3]     = nxt_timeout;
    nxt_status[5:4]   = nxt_sel;
    nxt_status[7:6]   = nxt_code;
    nxt_status[15:8]  = nxt_opcode[7:0];
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      state       <= IDLE;
      k           <= 2'd0;
      sel         <= 2'd0;
      base        <= '0;
      start_d     <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      timeout     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_adr_o    <= '0;
      desc_opcode <= '0;
      desc_src    <= '0;
      desc_dst    <= '0;
      desc_count  <= '0;
      desc_valid  <= 1'b0;
      status_reg  <= '0;
    end else begin
      state       <= nxt_state;
      k           <= nxt_k;
      sel         <= nxt_sel;
      base        <= nxt_base;
      start_d     <= control_reg[0];
      done        <= nxt_done;
      err         <= nxt_err;
      timeout     <= nxt_timeout;
      wb_cyc_o    <= nxt_cyc;
      wb_stb_o    <= nxt_stb;
      wb_adr_o    <= nxt_adr;
      desc_opcode <= nxt_opcode;
      desc_src    <= nxt_src;
      desc_dst    <= nxt_dst;
      desc_count  <= nxt_count;
      desc_valid  <= nxt_valid;
      status_reg  <= nxt_status;
    end
  end

`ifdef WB_DSP_FETCH_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wdog;

  // Fires on the last stalled cycle so cyc drops exactly TIMEOUT cycles after stb rose.
  assign timeout_hit = (state == FETCH) && wb_stb_o && !wb_ack_i && !wb_err_i &&
                       (wdog == TMO_LAST);

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      wdog <= 8'd0;
    end else if (start_go || wb_ack_i || timeout_hit || abort) begin
      wdog <= 8'd0;
    end else if ((state == FETCH) && wb_stb_o && !wb_err_i) begin
      wdog <= wdog + 8'd1;
    end
  end
`else
  logic [8:0] unused_cfg;
  assign timeout_hit = 1'b0;
  assign unused_cfg  = {8'(TIMEOUT), start_go};
`endif

endmodule

// File: tb/tb_wb_dsp_equation_fetch.sv
// Self-checking bench for wb_dsp_equation_fetch: vector table, randomized sequences against a
// transaction-level model, and hand-written abort / retrigger / reset / watchdog sequences.
module tb_wb_dsp_equation_fetch;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [3:0]  ws;
    int          errw;
    int          rdly;
    logic [7:0]  exp_low;
  } vec_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] control_reg;
  logic [31:0] eq_addr [4];
  logic [31:0] status_reg, wb_adr_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] desc_opcode, desc_src, desc_dst, desc_count;
  logic        desc_valid, desc_ready, engine_done;

  logic        slave_on, err_en, req_ok;
  logic [3:0]  wait_states, wait_ctr;
  logic [31:0] err_addr, mem_seed;
  logic [31:0] reads [$];
  logic [31:0] model_desc [4];
  int          errors = 0;
  int          checks = 0;

  always #5 wb_clk = ~wb_clk;

  wb_dsp_equation_fetch #(.dw(32), .aw(32), .DESC_WORDS(4), .TIMEOUT(8)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .control_reg(control_reg),
    .equation0_address_reg(eq_addr[0]), .equation1_address_reg(eq_addr[1]),
    .equation2_address_reg(eq_addr[2]), .equation3_address_reg(eq_addr[3]),
    .status_reg(status_reg), .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .desc_opcode(desc_opcode), .desc_src(desc_src), .desc_dst(desc_dst),
    .desc_count(desc_count), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .engine_done(engine_done)
  );

  // Slave memory: a fixed table for the documented example when seed is 0, else a hash.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] seed);
    if (seed == 32'd0) begin
      case (a)
        32'h100: return 32'h0000_00A5;
        32'h104: return 32'h0000_1000;
        32'h108: return 32'h0000_2000;
        32'h10C: return 32'h0000_0010;
        default: ;
      endcase
    end
    return (a * 32'h9E37_79B1) ^ seed ^ {a[15:0], a[31:16]};
  endfunction

  assign req_ok   = slave_on && wb_cyc_o && wb_stb_o && (wait_ctr >= wait_states);
  assign wb_ack_i = req_ok;
  assign wb_err_i = req_ok && err_en && (wb_adr_o == err_addr);
  assign wb_dat_i = mem_word(wb_adr_o, mem_seed);

  always @(posedge wb_clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wait_ctr <= wait_ctr + 4'd1;
    else wait_ctr <= 4'd0;
    if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) reads.push_back(wb_adr_o);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  // Runs one start..completion sequence and checks it against the transaction model.
  task automatic apply_stimulus(input logic [1:0] sel, input logic [3:0] ws, input int errw,
                                input int rdly, input bit hold, input bit stop_exec,
                                output logic [31:0] vstat);
    logic [31:0] base;
    logic [31:0] exp_desc [4];
    int          n, edges;
    bit          got_valid, e;
    base = {eq_addr[sel][31:2], 2'b00};
    e    = (errw < 4);
    n    = e ? errw : 4;
    exp_desc = model_desc;
    for (int i = 0; i < n; i++) exp_desc[i] = mem_word(base + 32'(4 * i), mem_seed);
    wait_states = ws;
    err_en      = e;
    err_addr    = base + 32'(4 * errw);
    reads.delete();
    vstat       = 32'd0;
    control_reg = {29'd0, sel, 1'b1};
    tick();
    if (!hold) control_reg[0] = 1'b0;
    check_output("start_status", status_reg, {16'd0, model_desc[0][7:0], 2'd1, sel, 4'b0001});
    got_valid = 1'b0;
    edges     = 1;
    for (int i = 0; i < 300 && !got_valid && status_reg[0]; i++) begin
      tick();
      edges++;
      got_valid = desc_valid;
    end
    model_desc = exp_desc;
    check_output("valid_seen", 32'(got_valid), 32'(!e));
    if (got_valid) begin
      vstat = status_reg;
      check_output("valid_latency", 32'(edges), 32'(4 * (int'(ws) + 2)));
      check_output("valid_status", status_reg, {16'd0, exp_desc[0][7:0], 2'd2, sel, 4'b0001});
      for (int d = 0; d < rdly; d++) tick();
      check_output("valid_hold", {31'd0, desc_valid}, 32'd1);
      desc_ready = 1'b1;
      tick();
      desc_ready = 1'b0;
      check_output("valid_drop", {31'd0, desc_valid}, 32'd0);
      check_output("exec_status", status_reg, {16'd0, exp_desc[0][7:0], 2'd3, sel, 4'b0001});
      if (stop_exec) return;
      tick();
      engine_done = 1'b1;
      tick();
      engine_done = 1'b0;
    end
    check_output("final_status", status_reg,
                 {16'd0, exp_desc[0][7:0], 2'd0, sel, 1'b0, e, !e, 1'b0});
    check_output("desc_opcode", desc_opcode, exp_desc[0]);
    check_output("desc_src", desc_src, exp_desc[1]);
    check_output("desc_dst", desc_dst, exp_desc[2]);
    check_output("desc_count", desc_count, exp_desc[3]);
    check_output("read_count", 32'(reads.size()), 32'(n));
    for (int i = 0; i < n && i < reads.size(); i++)
      check_output($sformatf("read_addr%0d", i), reads[i], base + 32'(4 * i));
    check_output("cyc_idle", {31'd0, wb_cyc_o}, 32'd0);
  endtask

  initial begin
    vec_t        vecs [6];
    logic [31:0] vstat;
    int          n;

    vecs[0] = '{2'd1, 32'h0000_0102, 4'd0, 4, 0, 8'h12};
    vecs[1] = '{2'd0, 32'h2000_0000, 4'd2, 4, 3, 8'h02};
    vecs[2] = '{2'd3, 32'hFFFF_FFFA, 4'd1, 4, 1, 8'h32};
    vecs[3] = '{2'd2, 32'h0000_0400, 4'd0, 2, 0, 8'h24};
    vecs[4] = '{2'd1, 32'h0000_0803, 4'd3, 0, 0, 8'h14};
    vecs[5] = '{2'd2, 32'h0000_0055, 4'd0, 4, 2, 8'h22};

    wb_rst = 1'b0;
    control_reg = 32'd0;
    for (int i = 0; i < 4; i++) eq_addr[i] = 32'd0;
    for (int i = 0; i < 4; i++) model_desc[i] = 32'd0;
    desc_ready = 1'b0;
    engine_done = 1'b0;
    slave_on = 1'b1;
    err_en = 1'b0;
    err_addr = 32'd0;
    wait_states = 4'd0;
    mem_seed = 32'd0;
    repeat (3) tick();
    check_output("rst_status", status_reg, 32'd0);
    check_output("rst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check_output("rst_valid", {31'd0, desc_valid}, 32'd0);
    check_output("rst_adr", wb_adr_o, 32'd0);
    check_output("rst_opcode", desc_opcode, 32'd0);
    wb_rst = 1'b1;
    tick();
    check_output("const_bus", {23'd0, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o}, {23'd0, 4'hF, 1'b0, 3'd0, 2'd0});
    check_output("idle_status", status_reg, 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 4; j++) eq_addr[j] = $urandom;
      eq_addr[vecs[i].sel] = vecs[i].addr;
      mem_seed = (i == 0) ? 32'd0 : ($urandom | 32'd1);
      apply_stimulus(vecs[i].sel, vecs[i].ws, vecs[i].errw, vecs[i].rdly, 1'b0, 1'b0, vstat);
      check_output($sformatf("vec%0d_low", i), {24'd0, status_reg[7:0]}, {24'd0, vecs[i].exp_low});
      if (i == 0) begin
        check_output("example_valid_status", vstat, 32'h0000_A591);
        check_output("example_done_status", status_reg, 32'h0000_A512);
        check_output("example_count", desc_count, 32'h0000_0010);
      end
      tick();
    end

    $display("[TB] randomized sequences");
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 4; j++) eq_addr[j] = $urandom;
      mem_seed = $urandom | 32'd1;
      apply_stimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4,
                     int'($urandom_range(0, 3)), 1'b0, 1'b0, vstat);
      tick();
    end

    $display("[TB] retrigger");
    eq_addr[3] = 32'h0000_3000;
    apply_stimulus(2'd3, 4'd1, 4, 0, 1'b1, 1'b0, vstat);
    repeat (5) tick();
    check_output("hold_reads", 32'(reads.size()), 32'd4);
    check_output("hold_done", {30'd0, status_reg[1:0]}, 32'd2);
    control_reg[0] = 1'b0;
    tick();
    apply_stimulus(2'd3, 4'd0, 4, 1, 1'b0, 1'b0, vstat);
    tick();

    $display("[TB] abort in execute");
    eq_addr[2] = 32'h0000_4444;
    apply_stimulus(2'd2, 4'd1, 4, 0, 1'b0, 1'b1, vstat);
    control_reg[31] = 1'b1;
    tick();
    control_reg = 32'd0;
    check_output("abort_status", status_reg, {16'd0, model_desc[0][7:0], 2'd0, 2'd2, 4'b0000});
    check_output("abort_valid", {31'd0, desc_valid}, 32'd0);
    engine_done = 1'b1;
    tick();
    engine_done = 1'b0;
    tick();
    check_output("abort_done_ignored", status_reg, {16'd0, model_desc[0][7:0], 2'd0, 2'd2, 4'b0000});

    $display("[TB] stalled slave");
    slave_on = 1'b0;
    err_en = 1'b0;
    eq_addr[0] = 32'h0000_5000;
    control_reg = 32'd1;
    tick();
    control_reg = 32'd0;
`ifdef WB_DSP_FETCH_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 50 && wb_cyc_o; i++) begin
      tick();
      n++;
    end
    check_output("timeout_cycles", 32'(n), 32'd8);
    check_output("timeout_bits", {28'd0, status_reg[3:0]}, 32'hC);
`else
    n = 0;
    repeat (40) tick();
    check_output("stall_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd3);
    check_output("stall_bits", {28'd0, status_reg[3:0]}, 32'd1);
    control_reg[31] = 1'b1;
    tick();
    control_reg = 32'd0;
    check_output("abort_fetch_cyc", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check_output("abort_fetch_state", {30'd0, status_reg[7:6]}, 32'd0);
`endif
    tick();

    $display("[TB] reset during fetch");
    eq_addr[1] = 32'h0000_6000;
    control_reg = 32'd3;
    tick();
    control_reg = 32'd0;
    tick();
    #2;
    wb_rst = 1'b0;
    #1;
    check_output("arst_cyc_stb", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
    check_output("arst_valid", {31'd0, desc_valid}, 32'd0);
    check_output("arst_status", status_reg, 32'd0);
    check_output("arst_opcode", desc_opcode, 32'd0);
    tick();
    wb_rst = 1'b1;
    slave_on = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
